// File: rtl/alu_dot8_pipe.sv
`timescale 1ns/1ps
// alu_dot8_pipe
// Two-stage elastic packed-int8 dot-product PE on the DOT8 port of the ALU PE
// switch. Each lane computes the 4-way dot product of the byte lanes of rs1
// and rs2 (signed or unsigned). The result is sign-extended to 32 bits.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   execute_valid     - request valid
//   execute_ready     - request accepted when valid & ready
//   execute_unsigned  - 1: zero-extend bytes (DOT8U), 0: sign-extend (DOT8)
//   execute_tmask     - active-lane mask
//   execute_rs1/rs2   - packed byte operands, 32 bits per lane
//   execute_tag       - opaque side-band, carried unchanged
//   result_valid      - result valid (S2 register)
//   result_ready      - consumer ready
//   result_tmask      - lane mask of the result
//   result_data       - per-lane dot product, 32 bits per lane
//   result_tag        - side-band of the result
module alu_dot8_pipe #(
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      execute_valid,
    output logic                      execute_ready,
    input  logic                      execute_unsigned,
    input  logic [NUM_LANES-1:0]      execute_tmask,
    input  logic [NUM_LANES*32-1:0]   execute_rs1,
    input  logic [NUM_LANES*32-1:0]   execute_rs2,
    input  logic [TAG_WIDTH-1:0]      execute_tag,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [NUM_LANES-1:0]      result_tmask,
    output logic [NUM_LANES*32-1:0]   result_data,
    output logic [TAG_WIDTH-1:0]      result_tag
);

    logic                     s1_valid;
    logic [NUM_LANES-1:0]     s1_tmask;
    logic [TAG_WIDTH-1:0]     s1_tag;
    logic signed [16:0]       s1_prod [NUM_LANES][4];

    logic signed [16:0]       prod_next [NUM_LANES][4];
    logic signed [16:0]       a_x;
    logic signed [16:0]       b_x;
    logic signed [18:0]       acc;
    logic [NUM_LANES*32-1:0]  sum_next;

    logic en1;
    logic en2;

    // S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
    assign en2           = ~result_valid | result_ready;
    assign en1           = ~s1_valid | en2;
    assign execute_ready = en1;

    // Byte products: each byte is extended to 9 significant bits (sign or zero)
    // and carried at 17 bits so the product fits without truncation.
    always_comb begin
        a_x = '0;
        b_x = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                a_x = {{9{~execute_unsigned & execute_rs1[l*32 + i*8 + 7]}},
                       execute_rs1[l*32 + i*8 +: 8]};
                b_x = {{9{~execute_unsigned & execute_rs2[l*32 + i*8 + 7]}},
                       execute_rs2[l*32 + i*8 +: 8]};
                prod_next[l][i] = a_x * b_x;
            end
        end
    end

    // Adder tree over the S1 products; inactive lanes are forced to 0 because
    // their product registers may hold data from an older request.
    always_comb begin
        sum_next = '0;
        acc      = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            acc = '0;
            for (int unsigned i = 0; i < 4; i++) begin
                acc = acc + {{2{s1_prod[l][i][16]}}, s1_prod[l][i]};
            end
            if (s1_tmask[l]) begin
                sum_next[l*32 +: 32] = {{13{acc[18]}}, acc};
            end
        end
    end

    // Stage 1: products, mask, tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_tmask <= '0;
            s1_tag   <= '0;
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    s1_prod[l][i] <= '0;
                end
            end
        end else if (en1) begin
            s1_valid <= execute_valid;
            if (execute_valid) begin
                s1_tmask <= execute_tmask;
                s1_tag   <= execute_tag;
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    if (execute_tmask[l]) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            s1_prod[l][i] <= prod_next[l][i];
                        end
                    end
                end
            end
        end
    end

    // Stage 2: final sum drives the result ports directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid <= 1'b0;
            result_tmask <= '0;
            result_data  <= '0;
            result_tag   <= '0;
        end else if (en2) begin
            result_valid <= s1_valid;
            if (s1_valid) begin
                result_tmask <= s1_tmask;
                result_data  <= sum_next;
                result_tag   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_dot8_pipe.sv
`timescale 1ns/1ps
module tb_alu_dot8_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         execute_valid;
    logic         execute_ready;
    logic         execute_unsigned;
    logic [3:0]   execute_tmask;
    logic [127:0] execute_rs1;
    logic [127:0] execute_rs2;
    logic [63:0]  execute_tag;
    logic         result_valid;
    logic         result_ready;
    logic [3:0]   result_tmask;
    logic [127:0] result_data;
    logic [63:0]  result_tag;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tmask;
        logic [63:0]  tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_dot8_pipe #(.NUM_LANES(4), .TAG_WIDTH(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .execute_valid    (execute_valid),
        .execute_ready    (execute_ready),
        .execute_unsigned (execute_unsigned),
        .execute_tmask    (execute_tmask),
        .execute_rs1      (execute_rs1),
        .execute_rs2      (execute_rs2),
        .execute_tag      (execute_tag),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_tmask     (result_tmask),
        .result_data      (result_data),
        .result_tag       (result_tag)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: plain integer dot product per active lane.
    function automatic logic [127:0] ref_dot(input logic [127:0] a, input logic [127:0] b,
                                             input logic uns, input logic [3:0] m);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) begin
                int s;
                s = 0;
                for (int i = 0; i < 4; i++) begin
                    logic [7:0] ab;
                    logic [7:0] bb;
                    int x;
                    int y;
                    ab = a[l*32 + i*8 +: 8];
                    bb = b[l*32 + i*8 +: 8];
                    if (uns) begin
                        x = int'(ab);
                        y = int'(bb);
                    end else begin
                        x = $signed(ab);
                        y = $signed(bb);
                    end
                    s = s + x * y;
                end
                r[l*32 +: 32] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic v, input logic [127:0] a, input logic [127:0] b,
                         input logic u, input logic [3:0] m, input logic [63:0] t);
        execute_valid    = v;
        execute_rs1      = a;
        execute_rs2      = b;
        execute_unsigned = u;
        execute_tmask    = m;
        execute_tag      = t;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        result_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_total++;
        if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", result_valid);
        else n_pass++;
        n_total++;
        if (result_data !== '0) $display("FAIL reset_data: got %h expected 0", result_data);
        else n_pass++;
        n_total++;
        if (result_tmask !== '0) $display("FAIL reset_tmask: got %h expected 0", result_tmask);
        else n_pass++;
        n_total++;
        if (result_tag !== '0) $display("FAIL reset_tag: got %h expected 0", result_tag);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (execute_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", execute_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        result_ready = 1'b1;
        // upper lanes carry junk that must be masked off
        drive(1'b1, {{3{32'h7F80_11FF}}, 32'h0102_0304}, {{3{32'h7F7F_8001}}, 32'h0101_0101},
              1'b0, 4'b0001, 64'hB0);
        #1;
        n_total++;
        if (execute_ready !== 1'b1) $display("FAIL basic_accept: got %b expected 1", execute_ready);
        else n_pass++;
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_total++;
        if (result_valid !== 1'b0) $display("FAIL basic_early: got %b expected 0", result_valid);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (result_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", result_valid);
        else n_pass++;
        n_total++;
        if (result_data !== 128'h0000000A) $display("FAIL basic_data: got %h expected %h", result_data, 128'h0000000A);
        else n_pass++;
        n_total++;
        if (result_tag !== 64'hB0 || result_tmask !== 4'b0001)
            $display("FAIL basic_side: got tag %h mask %b expected tag b0 mask 0001", result_tag, result_tmask);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (result_valid !== 1'b0) $display("FAIL basic_drain: got %b expected 0", result_valid);
        else n_pass++;
    endtask

    task automatic test_extremes();
        logic [31:0] e_a [4];
        logic [31:0] e_b [4];
        logic        e_u [4];
        logic [31:0] e_r [4];
        e_a = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8080_8080, 32'hFFFF_FFFF};
        e_b = '{32'h0101_0101, 32'h0101_0101, 32'h8080_8080, 32'hFFFF_FFFF};
        e_u = '{1'b0, 1'b1, 1'b0, 1'b1};
        e_r = '{32'hFFFF_FFFC, 32'h0000_03FC, 32'h0001_0000, 32'h0003_F804};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            result_ready = 1'b1;
            if (c < 4) drive(1'b1, {4{e_a[c]}}, {4{e_b[c]}}, e_u[c], 4'b1111, 64'(c + 32));
            else       drive(1'b0, '0, '0, 1'b0, '0, '0);
            #1;
            if (c >= 2 && c < 6) begin
                n_total++;
                if (result_valid !== 1'b1 || result_data !== {4{e_r[c-2]}} || result_tag !== 64'(c + 30))
                    $display("FAIL extreme_%0d: got v=%b data %h tag %h expected data %h tag %h",
                             c - 2, result_valid, result_data, result_tag, {4{e_r[c-2]}}, 64'(c + 30));
                else n_pass++;
            end
        end
    endtask

    task automatic test_streaming();
        logic [127:0] a, b;
        logic         u;
        logic [3:0]   m;
        logic [127:0] ed [8];
        logic [3:0]   em [8];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            result_ready = 1'b1;
            if (c < 8) begin
                a = rnd128();
                b = rnd128();
                u = 1'($urandom_range(0, 1));
                m = 4'($urandom_range(0, 15));
                ed[c] = ref_dot(a, b, u, m);
                em[c] = m;
                drive(1'b1, a, b, u, m, 64'(c));
            end else begin
                drive(1'b0, '0, '0, 1'b0, '0, '0);
            end
            #1;
            if (c < 8) begin
                n_total++;
                if (execute_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %b expected 1", c, execute_ready);
                else n_pass++;
            end
            if (c >= 2 && c < 10) begin
                n_total++;
                if (result_valid !== 1'b1 || result_tag !== 64'(c - 2) ||
                    result_data !== ed[c-2] || result_tmask !== em[c-2])
                    $display("FAIL stream_out_%0d: got v=%b tag %h data %h mask %b expected tag %h data %h mask %b",
                             c - 2, result_valid, result_tag, result_data, result_tmask,
                             64'(c - 2), ed[c-2], em[c-2]);
                else n_pass++;
            end else begin
                n_total++;
                if (result_valid !== 1'b0) $display("FAIL stream_idle_%0d: got %b expected 0", c, result_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] ca, cb;
        logic         cu;
        logic [3:0]   cm;
        logic [127:0] snap_d;
        logic [63:0]  snap_t;
        logic [3:0]   snap_m;
        logic         have_snap;
        int           sent;
        int           got;
        exp_t         e;
        sent = 0;
        got = 0;
        have_snap = 1'b0;
        snap_d = '0;
        snap_t = '0;
        snap_m = '0;
        sb.delete();
        ca = rnd128(); cb = rnd128(); cu = 1'($urandom_range(0, 1)); cm = 4'($urandom_range(1, 15));
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            result_ready = (c >= 5);
            if (sent < 4) drive(1'b1, ca, cb, cu, cm, 64'(100 + sent));
            else          drive(1'b0, '0, '0, 1'b0, '0, '0);
            #1;
            if (c < 5) begin
                n_total++;
                if (execute_ready !== (sent < 2))
                    $display("FAIL bp_ready_%0d: got %b expected %b", c, execute_ready, sent < 2);
                else n_pass++;
                if (c >= 2) begin
                    n_total++;
                    if (result_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b expected 1", c, result_valid);
                    else n_pass++;
                    if (have_snap) begin
                        n_total++;
                        if (result_data !== snap_d || result_tag !== snap_t || result_tmask !== snap_m)
                            $display("FAIL bp_stable_%0d: got data %h tag %h mask %b expected data %h tag %h mask %b",
                                     c, result_data, result_tag, result_tmask, snap_d, snap_t, snap_m);
                        else n_pass++;
                    end else begin
                        snap_d = result_data;
                        snap_t = result_tag;
                        snap_m = result_tmask;
                        have_snap = 1'b1;
                    end
                end
            end
            if (execute_valid && execute_ready) begin
                e.data = ref_dot(ca, cb, cu, cm);
                e.tmask = cm;
                e.tag = 64'(100 + sent);
                sb.push_back(e);
                sent++;
                ca = rnd128(); cb = rnd128(); cu = 1'($urandom_range(0, 1)); cm = 4'($urandom_range(1, 15));
            end
            if (result_valid && result_ready) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL bp_extra: got tag %h expected no result", result_tag);
                end else begin
                    e = sb.pop_front();
                    got++;
                    if (result_tag !== e.tag || result_data !== e.data || result_tmask !== e.tmask)
                        $display("FAIL bp_order: got tag %h data %h mask %b expected tag %h data %h mask %b",
                                 result_tag, result_data, result_tmask, e.tag, e.data, e.tmask);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (got !== 4 || sb.size() !== 0)
            $display("FAIL bp_count: got %0d results (%0d pending) expected 4 (0 pending)", got, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic [127:0] a, b, ed;
        logic         u;
        logic [3:0]   m;
        sb.delete();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            result_ready = 1'b1;
            drive(1'b1, rnd128(), rnd128(), 1'b0, 4'b1111, 64'(200 + c));
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_total++;
        if (result_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", result_valid);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (result_valid !== 1'b0 || result_data !== '0 || result_tag !== '0 || result_tmask !== '0)
            $display("FAIL mid_async_clear: got v=%b data %h tag %h mask %b expected all 0",
                     result_valid, result_data, result_tag, result_tmask);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (result_valid !== 1'b0) $display("FAIL mid_stale_%0d: got %b expected 0", c, result_valid);
            else n_pass++;
        end
        a = rnd128(); b = rnd128(); u = 1'($urandom_range(0, 1)); m = 4'($urandom_range(1, 15));
        ed = ref_dot(a, b, u, m);
        @(negedge clk);
        drive(1'b1, a, b, u, m, 64'h2AA);
        #1;
        n_total++;
        if (execute_ready !== 1'b1) $display("FAIL mid_ready: got %b expected 1", execute_ready);
        else n_pass++;
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_total++;
        if (result_valid !== 1'b0) $display("FAIL mid_early: got %b expected 0", result_valid);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (result_valid !== 1'b1 || result_data !== ed || result_tag !== 64'h2AA || result_tmask !== m)
            $display("FAIL mid_after: got v=%b data %h tag %h mask %b expected data %h tag 2aa mask %b",
                     result_valid, result_data, result_tag, result_tmask, ed, m);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [127:0] a, b;
        logic         u;
        logic [3:0]   m;
        logic         rr;
        logic [63:0]  tag;
        exp_t         e;
        sb.delete();
        tag = 64'h1000;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rr = ($urandom_range(0, 3) != 0);
            result_ready = rr;
            a = rnd128(); b = rnd128(); u = 1'($urandom_range(0, 1)); m = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 2) != 0), a, b, u, m, tag);
            #1;
            n_total++;
            if (execute_ready !== !(sb.size() == 2 && !rr))
                $display("FAIL rnd_ready_%0d: got %b expected %b", c, execute_ready, !(sb.size() == 2 && !rr));
            else n_pass++;
            if (sb.size() == 0) begin
                n_total++;
                if (result_valid !== 1'b0) $display("FAIL rnd_spurious_%0d: got %b expected 0", c, result_valid);
                else n_pass++;
            end
            if (execute_valid && execute_ready) begin
                e.data = ref_dot(a, b, u, m);
                e.tmask = m;
                e.tag = tag;
                sb.push_back(e);
                tag = tag + 1;
            end
            if (result_valid && result_ready && sb.size() != 0) begin
                e = sb.pop_front();
                n_total++;
                if (result_tag !== e.tag || result_data !== e.data || result_tmask !== e.tmask)
                    $display("FAIL rnd_result: got tag %h data %h mask %b expected tag %h data %h mask %b",
                             result_tag, result_data, result_tmask, e.tag, e.data, e.tmask);
                else n_pass++;
            end
        end
        for (int c = 0; c < 10 && sb.size() != 0; c++) begin
            @(negedge clk);
            result_ready = 1'b1;
            drive(1'b0, '0, '0, 1'b0, '0, '0);
            #1;
            if (result_valid) begin
                e = sb.pop_front();
                n_total++;
                if (result_tag !== e.tag || result_data !== e.data || result_tmask !== e.tmask)
                    $display("FAIL rnd_drain: got tag %h data %h mask %b expected tag %h data %h mask %b",
                             result_tag, result_data, result_tmask, e.tag, e.data, e.tmask);
                else n_pass++;
            end
        end
        n_total++;
        if (sb.size() !== 0) $display("FAIL rnd_timeout: got %0d pending expected 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        result_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        test_reset();
        test_basic();
        test_extremes();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
